// File: rtl/debug_slave_pkg.sv
// Shared defaults and channel state encoding for the system-clock debug slave.
package debug_slave_pkg;

    localparam int IR_W_DEF        = 2;
    localparam int N_CHAN_DEF      = 4;
    localparam int DATA_W_DEF      = 38;
    localparam int ACT_BIT_DEF     = 35;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } chan_state_e;

endpackage

// File: rtl/debug_sync_pulse.sv
// Multi-flop synchroniser for a TCK-domain level, followed by a rising-edge
// detector that yields a one-cycle pulse in the clk domain.
module debug_sync_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the previous value, not the one just written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pulse is formed from flop outputs only, so no path from async_in.
    assign pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/debug_slave_sysclk_mc.sv
// System-clock half of the JTAG debug slave: synchronises the update strobes,
// captures the shifted word and presents per-channel action/no-action requests.
module debug_slave_sysclk_mc
    import debug_slave_pkg::*;
#(
    parameter int IR_W        = IR_W_DEF,
    parameter int N_CHAN      = N_CHAN_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              vs_uir,
    input  logic              vs_udr,
    output logic [DATA_W-1:0] jdo,
    output logic [N_CHAN-1:0] act_valid,
    output logic [N_CHAN-1:0] noact_valid,
    input  logic [N_CHAN-1:0] req_ready,
    output logic [N_CHAN-1:0] ovf,
    output logic              unmapped,
    input  logic              clr_flags
);

    logic              uir_p;
    logic              udr_p;
    logic [IR_W-1:0]   ir_q;
    logic [IR_W-1:0]   ir_eff;
    logic [N_CHAN-1:0] hit;
    logic [N_CHAN-1:0] accept;
    logic [DATA_W-1:0] jdo_q;
    logic              unmapped_q;

    debug_sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .pulse    (uir_p)
    );

    debug_sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .pulse    (udr_p)
    );

    // A coincident IR update takes effect before the DR decode.
    assign ir_eff = uir_p ? ir_in : ir_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q       <= '0;
            jdo_q      <= '0;
            unmapped_q <= 1'b0;
        end else begin
            if (uir_p) begin
                ir_q <= ir_in;
            end
            if (|accept) begin
                jdo_q <= sr;
            end
            if (udr_p && !(|hit)) begin
                unmapped_q <= 1'b1;
            end else if (clr_flags) begin
                unmapped_q <= 1'b0;
            end
        end
    end

    assign jdo      = jdo_q;
    assign unmapped = unmapped_q;

    for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
        chan_state_e state_q;
        chan_state_e state_d;
        logic        act_q;
        logic        noact_q;
        logic        ovf_q;

        assign hit[g]    = udr_p && (ir_eff == IR_W'(g));
        assign accept[g] = hit[g] && ((state_q == ST_IDLE) || req_ready[g]);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // NOTE: default assignment first keeps this block free of latches.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: if (accept[g]) state_d = ST_PEND;
                ST_PEND: if (!accept[g] && req_ready[g]) state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                act_q   <= 1'b0;
                noact_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                if (accept[g]) begin
                    act_q   <= sr[ACT_BIT];
                    noact_q <= ~sr[ACT_BIT];
                end else if ((state_q == ST_PEND) && req_ready[g]) begin
                    act_q   <= 1'b0;
                    noact_q <= 1'b0;
                end
                // Set beats clear when both land in the same cycle.
                if (hit[g] && !accept[g]) begin
                    ovf_q <= 1'b1;
                end else if (clr_flags) begin
                    ovf_q <= 1'b0;
                end
            end
        end

        assign act_valid[g]   = act_q;
        assign noact_valid[g] = noact_q;
        assign ovf[g]         = ovf_q;
    end

endmodule

// File: tb/tb_debug_slave_sysclk_mc.sv
// Directed bench for debug_slave_sysclk_mc: a 4-channel instance plus a
// 3-channel instance sharing stimulus so IR value 3 is unmapped on the latter.
module tb_debug_slave_sysclk_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_uir;
    logic        vs_udr;
    logic [3:0]  req_ready;
    logic        clr_flags;

    logic [37:0] jdo;
    logic [3:0]  act;
    logic [3:0]  noact;
    logic [3:0]  ovf;
    logic        unm;

    logic [37:0] jdo3;
    logic [2:0]  act3;
    logic [2:0]  noact3;
    logic [2:0]  ovf3;
    logic        unm3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [37:0] jdo;
        logic [3:0]  act;
        logic [3:0]  noact;
        logic [3:0]  ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    debug_slave_sysclk_mc dut (
        .clk         (clk),
        .reset       (reset),
        .ir_in       (ir_in),
        .sr          (sr),
        .vs_uir      (vs_uir),
        .vs_udr      (vs_udr),
        .jdo         (jdo),
        .act_valid   (act),
        .noact_valid (noact),
        .req_ready   (req_ready),
        .ovf         (ovf),
        .unmapped    (unm),
        .clr_flags   (clr_flags)
    );

    debug_slave_sysclk_mc #(.N_CHAN(3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .ir_in       (ir_in),
        .sr          (sr),
        .vs_uir      (vs_uir),
        .vs_udr      (vs_udr),
        .jdo         (jdo3),
        .act_valid   (act3),
        .noact_valid (noact3),
        .req_ready   (req_ready[2:0]),
        .ovf         (ovf3),
        .unmapped    (unm3),
        .clr_flags   (clr_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input string tag, input logic [37:0] j,
                           input logic [3:0] a, input logic [3:0] na, input logic [3:0] o);
        exp_t e;
        e.tag = tag; e.jdo = j; e.act = a; e.noact = na; e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_jdo"},   64'(jdo),   64'(e.jdo));
            check({e.tag, "_act"},   64'(act),   64'(e.act));
            check({e.tag, "_noact"}, 64'(noact), 64'(e.noact));
            check({e.tag, "_ovf"},   64'(ovf),   64'(e.ovf));
        end
    endtask

    task automatic pulse_uir(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        tick(3);
    endtask

    // rdy/clr are applied only on the edge where the synchronised pulse decodes.
    task automatic pulse_udr(input logic [37:0] word, input logic [3:0] rdy, input logic clr,
                             input string tag, input logic [37:0] ej,
                             input logic [3:0] ea, input logic [3:0] ena, input logic [3:0] eo);
        sb_push(tag, ej, ea, ena, eo);
        sr     = word;
        vs_udr = 1'b1;
        tick(2);
        req_ready = rdy;
        clr_flags = clr;
        tick(1);
        req_ready = '0;
        clr_flags = 1'b0;
        sb_check();
        tick(1);
        vs_udr = 1'b0;
        tick(3);
    endtask

    task automatic release_chan(input logic [3:0] rdy);
        req_ready = rdy;
        tick(1);
        req_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        ir_in     = '0;
        sr        = '0;
        vs_uir    = 1'b0;
        vs_udr    = 1'b0;
        req_ready = '0;
        clr_flags = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);

        check("rst_jdo",   64'(jdo),   64'h0);
        check("rst_act",   64'(act),   64'h0);
        check("rst_noact", 64'(noact), 64'h0);
        check("rst_ovf",   64'(ovf),   64'h0);
        check("rst_unm",   64'(unm),   64'h0);

        // Exact latency: nothing after edge 2, effects after edge 3.
        sb_push("lat", 38'h08_0000_0001, 4'b0001, 4'b0000, 4'b0000);
        sr     = 38'h08_0000_0001;
        vs_udr = 1'b1;
        tick(2);
        check("lat_early_jdo", 64'(jdo), 64'h0);
        check("lat_early_act", 64'(act), 64'h0);
        tick(1);
        sb_check();
        check("lat_act3", 64'(act3), 64'h1);
        tick(1);
        vs_udr = 1'b0;
        tick(3);
        check("lat_hold_act", 64'(act), 64'h1);
        release_chan(4'b0001);
        check("lat_done_act", 64'(act), 64'h0);

        // No-action path on channel 2, held until ready.
        pulse_uir(2'd2);
        pulse_udr(38'h0_1234_5678, 4'b0000, 1'b0, "noact",
                  38'h0_1234_5678, 4'b0000, 4'b0100, 4'b0000);
        tick(5);
        check("noact_hold", 64'(noact), 64'h4);
        release_chan(4'b0100);
        check("noact_done", 64'(noact), 64'h0);

        // Overflow on busy channel 1.
        pulse_uir(2'd1);
        pulse_udr(38'h08_0000_00AA, 4'b0000, 1'b0, "ovf_first",
                  38'h08_0000_00AA, 4'b0010, 4'b0000, 4'b0000);
        pulse_udr(38'h00_0000_00BB, 4'b0000, 1'b0, "ovf_drop",
                  38'h08_0000_00AA, 4'b0010, 4'b0000, 4'b0010);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("ovf_clr", 64'(ovf), 64'h0);
        release_chan(4'b0010);
        check("ovf_done_act", 64'(act), 64'h0);

        // Ready and new command in the same cycle on channel 3.
        pulse_uir(2'd3);
        pulse_udr(38'h08_0000_0C0C, 4'b0000, 1'b0, "simul_first",
                  38'h08_0000_0C0C, 4'b1000, 4'b0000, 4'b0000);
        pulse_udr(38'h00_0000_0D0D, 4'b1000, 1'b0, "simul_new",
                  38'h00_0000_0D0D, 4'b0000, 4'b1000, 4'b0000);
        tick(3);
        check("simul_hold", 64'(noact), 64'h8);
        release_chan(4'b1000);
        check("simul_done", 64'(noact), 64'h0);

        // Unmapped IR on the 3-channel instance.
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("unm_clr0", 64'(unm3), 64'h0);
        pulse_uir(2'd0);
        pulse_udr(38'h08_0000_0E0E, 4'b0000, 1'b0, "unm_pre",
                  38'h08_0000_0E0E, 4'b0001, 4'b0000, 4'b0000);
        check("unm_pre_jdo3", 64'(jdo3), 64'h08_0000_0E0E);
        release_chan(4'b0001);
        pulse_uir(2'd3);
        pulse_udr(38'h00_0000_0F0F, 4'b0000, 1'b0, "unm_ch3",
                  38'h00_0000_0F0F, 4'b0000, 4'b1000, 4'b0000);
        check("unm_set",      64'(unm3),   64'h1);
        check("unm_jdo3",     64'(jdo3),   64'h08_0000_0E0E);
        check("unm_act3",     64'(act3),   64'h0);
        check("unm_noact3",   64'(noact3), 64'h0);
        check("unm_full_unm", 64'(unm),    64'h0);
        release_chan(4'b1000);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("unm_clr1", 64'(unm3), 64'h0);
        pulse_udr(38'h08_0000_0707, 4'b0000, 1'b1, "unm_setwins",
                  38'h08_0000_0707, 4'b1000, 4'b0000, 4'b0000);
        check("unm_setwins", 64'(unm3), 64'h1);
        release_chan(4'b1000);

        // Async reset with two channels pending.
        pulse_uir(2'd0);
        pulse_udr(38'h08_0000_1111, 4'b0000, 1'b0, "ar_ch0",
                  38'h08_0000_1111, 4'b0001, 4'b0000, 4'b0000);
        pulse_uir(2'd1);
        pulse_udr(38'h00_0000_2222, 4'b0000, 1'b0, "ar_ch1",
                  38'h00_0000_2222, 4'b0001, 4'b0010, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check("ar_jdo",   64'(jdo),   64'h0);
        check("ar_act",   64'(act),   64'h0);
        check("ar_noact", 64'(noact), 64'h0);
        check("ar_unm3",  64'(unm3),  64'h0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("ar_post_act", 64'(act), 64'h0);
        // ir_q was cleared, so this targets channel 0.
        pulse_udr(38'h08_0000_3333, 4'b0000, 1'b0, "ar_fresh",
                  38'h08_0000_3333, 4'b0001, 4'b0000, 4'b0000);
        release_chan(4'b0001);

        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_slave_sysclk_mc.md
Name: debug_slave_sysclk_mc

Overview:
- System-clock half of the JTAG debug slave, generalised to N command channels and configurable IR/data widths.
- Takes the TCK-domain shift register and virtual-JTAG update strobes, synchronises the strobes into clk, and captures the shifted word into jdo.
- Decodes the latched IR into a per-channel action or no-action request, held under a valid/ready handshake.
- Flags commands that arrive while their channel is still busy.

Parameters:
IR_W, 2, virtual-JTAG instruction width
N_CHAN, 4, number of command channels; must be <= 2**IR_W; IR values >= N_CHAN are unmapped
DATA_W, 38, shift-register / jdo width
ACT_BIT, 35, jdo bit selecting action (1) versus no-action (0)
SYNC_STAGES, 2, synchroniser depth for vs_udr and vs_uir; must be >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ir_in  in  IR_W  TCK-domain IR; stable around vs_uir/vs_udr
sr  in  DATA_W  TCK-domain shift register; stable while vs_udr is high
vs_uir  in  1  async update-IR level from TCK domain
vs_udr  in  1  async update-DR level from TCK domain
jdo  out  DATA_W  last accepted command word
act_valid  out  N_CHAN  per channel: pending request is an action
noact_valid  out  N_CHAN  per channel: pending request is a no-action
req_ready  in  N_CHAN  consumer accepts the pending request of that channel
ovf  out  N_CHAN  sticky per channel: command dropped because the channel was busy
unmapped  out  1  sticky: update-DR received with latched IR >= N_CHAN
clr_flags  in  1  synchronous clear of ovf and unmapped

Behaviour:
- Reset (async assert, sync deassert into logic): all sync flops, jdo, act_valid, noact_valid, ovf, unmapped and ir_q = 0; every channel returns to IDLE.
- Reset mid-transaction discards any pending request. The consumer must not see a valid after reset.
- Synchronisers: vs_uir and vs_udr each pass through SYNC_STAGES flops plus one edge-detect flop. A rising edge yields a one-cycle internal pulse (uir_p, udr_p); falling edges are ignored.
- Latency: pulse and its effects become visible SYNC_STAGES+1 clk edges after the first edge that samples the strobe high.
- uir_p: ir_q <= ir_in (sampled directly; stable by JTAG protocol).
- udr_p, decoding with ch = ir_q:
  - If ch >= N_CHAN: set unmapped; jdo unchanged; no request.
  - Else if channel ch is IDLE, or PEND with req_ready[ch]=1 in the same cycle: jdo <= sr; channel ch enters PEND (stays PEND if it was already PEND). Assert act_valid[ch] if sr[ACT_BIT]=1, else noact_valid[ch].
  - Else (PEND and not ready): command dropped; jdo unchanged so the pending word stays stable; ovf[ch] <= 1.
- uir_p and udr_p in the same cycle: IR update applies first; the udr decode uses the new ir_in.
- Per-channel FSM with two states:
  - IDLE -> PEND on an accepted udr_p.
  - PEND -> IDLE when req_ready[ch]=1 and no new accepted command targets ch in that cycle.
- act_valid[ch] and noact_valid[ch] are mutually exclusive, asserted only in PEND, and held stable until the handshake.
- req_ready while IDLE has no effect.
- Only one channel can be targeted per cycle. Other channels may complete handshakes in the same cycle independently.
- clr_flags clears ovf and unmapped. If a set event coincides with clr_flags, the set wins.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package debug_slave_pkg: default widths (IR_W, DATA_W, ACT_BIT) and the channel FSM state enum (ST_IDLE, ST_PEND).
- Natural sub-module: debug_sync_pulse. Parametrised SYNC_STAGES synchroniser plus rising-edge detector, instantiated twice (uir, udr); async active-high reset.
- Channel FSMs are generated in a loop in the top level.

Test Plan:
- Reset then idle: after reset pulse, jdo=0, all valids 0, ovf=0, unmapped=0. A vs_udr pulse with ir_q=0 and sr=38'h08_0000_0001 (bit35=1) -> act_valid=4'b0001 and jdo=38'h08_0000_0001 at exactly edge SYNC_STAGES+1 (3 with defaults).
- No-action path: uir with ir_in=2, then udr with sr[35]=0, sr=38'h0_1234_5678 -> noact_valid=4'b0100. Hold req_ready=0 for 5 cycles: valid stays high; req_ready[2]=1 -> valid drops next edge.
- Overflow: channel 1 PEND and not ready; second udr with different sr -> jdo keeps the first word, ovf=4'b0010, act/noact state unchanged. clr_flags -> ovf=0.
- Simultaneous ready and new command: channel 3 PEND; udr arrives with req_ready[3]=1 in the same cycle -> jdo takes the new word, channel 3 stays PEND with the new polarity, ovf[3]=0.
- Unmapped: N_CHAN=3, ir=3, udr -> unmapped=1, jdo unchanged, no valids. clr_flags in the same cycle as a new unmapped udr -> unmapped=1.
- Async reset mid-PEND: two channels pending, assert reset between clock edges -> all outputs 0 immediately. After deassert, a fresh udr is accepted normally.
